// File: rtl/spin_pkg.sv
// Shared definitions for the spindle ramp controller and the PWM stage.
package spin_pkg;

    localparam int SPEED_BITS = 4;
    localparam int FRAME_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_STOP = 2'd2,
        ST_FLIP = 2'd3
    } spin_state_e;

    typedef struct packed {
        logic                  dir;
        logic [SPEED_BITS-1:0] speed;
    } spin_target_t;

    // One saturating speed step toward the target; never wraps at either end.
    function automatic logic [SPEED_BITS-1:0] ramp_step(
        input logic [SPEED_BITS-1:0] cur,
        input logic [SPEED_BITS-1:0] tgt
    );
        logic [SPEED_BITS-1:0] nxt;
        if ((cur < tgt) && (cur != {SPEED_BITS{1'b1}})) begin
            nxt = cur + SPEED_BITS'(1);
        end else if ((cur > tgt) && (cur != {SPEED_BITS{1'b0}})) begin
            nxt = cur - SPEED_BITS'(1);
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/spin_frame_rx.sv
// Serial frame receiver: edge-detects f_en, shifts in 5 bits MSB first and
// presents the completed frame with a one-cycle frame_valid pulse.
module spin_frame_rx
    import spin_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  f_en,
    input  logic                  freq,
    output logic                  frame_valid,
    output logic [FRAME_BITS-1:0] frame_data
);

    logic                  f_en_prev_q, f_en_prev_d;
    logic [FRAME_BITS-2:0] shift_q, shift_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  fv_q, fv_d;
    logic [FRAME_BITS-1:0] data_q, data_d;

    // Next-state: shift a bit on each f_en rising edge while enabled; when disabled
    // everything holds (including an undelivered frame_valid).
    always_comb begin
        f_en_prev_d = f_en;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        fv_d        = fv_q;
        data_d      = data_q;
        if (en) begin
            fv_d = 1'b0;
            if (f_en && !f_en_prev_q) begin
                if (cnt_q == 3'(FRAME_BITS - 1)) begin
                    data_d = {shift_q, freq};
                    fv_d   = 1'b1;
                    cnt_d  = 3'd0;
                end else begin
                    shift_d = {shift_q[FRAME_BITS-3:0], freq};
                    cnt_d   = cnt_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            fv_d = fv_q;
        end
    end

    // Receiver state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_en_prev_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= 3'd0;
            fv_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            f_en_prev_q <= f_en_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            fv_q        <= fv_d;
            data_q      <= data_d;
        end
    end

    assign frame_valid = fv_q;
    assign frame_data  = data_q;

endmodule

// File: rtl/spin_ramp_ctrl.sv
// Spindle speed ramp controller: receives {dir, speed} frames and ramps the
// commanded speed one step per RAMP_DIV cycles, stopping before a reversal.
// Optional feature: define SPIN_WDOG_EN to add a frame-timeout watchdog that
// ramps the spindle to zero when no frame arrives for WDOG_CYCLES cycles.
module spin_ramp_ctrl
    import spin_pkg::*;
#(
    parameter int RAMP_DIV    = 16384,
    parameter int WDOG_CYCLES = 16777216
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  f_en,
    input  logic                  freq,
    output logic [SPEED_BITS-1:0] speed,
    output logic                  dir,
    output logic                  pwm_en,
    output logic                  busy
);

    localparam int              DIV_W    = $clog2(RAMP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    logic                  fv_s;
    logic [FRAME_BITS-1:0] fd_s;
    logic                  tick_s;

    spin_state_e           state_q, state_d;
    logic [SPEED_BITS-1:0] speed_q, speed_d;
    logic                  dir_q, dir_d;
    logic                  pwm_en_q, pwm_en_d;
    logic                  busy_q, busy_d;
    logic [DIV_W-1:0]      div_q, div_d;
    spin_target_t          tgt_q, tgt_d;
`ifdef SPIN_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic [31:0]           wdog_q, wdog_d;
`endif

    spin_frame_rx u_rx (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .f_en        (f_en),
        .freq        (freq),
        .frame_valid (fv_s),
        .frame_data  (fd_s)
    );

    assign tick_s = en && (div_q == DIV_LAST);

    // Next-state: divider, target latch, ramp FSM and output enables.
    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        dir_d    = dir_q;
        div_d    = div_q;
        tgt_d    = tgt_q;
        pwm_en_d = en && (speed_q != '0);
`ifdef SPIN_WDOG_EN
        wdog_d   = wdog_q;
`endif
        if (en) begin
            div_d = tick_s ? '0 : (div_q + DIV_W'(1));
            // A tick coinciding with a new frame still steps toward the old target.
            if (fv_s) begin
                tgt_d = fd_s;
            end else begin
                tgt_d = tgt_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!fv_s) begin
                        state_d = ST_IDLE;
                    end else if (fd_s[FRAME_BITS-1] == dir_q) begin
                        state_d = ST_RAMP;
                    end else if (speed_q != '0) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_FLIP;
                    end
                end
                ST_RAMP: begin
                    if (tick_s) begin
                        speed_d = ramp_step(speed_q, tgt_q.speed);
                    end else begin
                        speed_d = speed_q;
                    end
                    if (fv_s && (fd_s[FRAME_BITS-1] != dir_q)) begin
                        state_d = ST_STOP;
                    end else if (fv_s) begin
                        state_d = ST_RAMP;
                    end else if (speed_d == tgt_q.speed) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
                ST_STOP: begin
                    if (tick_s && (speed_q != '0)) begin
                        speed_d = speed_q - SPEED_BITS'(1);
                    end else begin
                        speed_d = speed_q;
                    end
                    if (fv_s && (fd_s[FRAME_BITS-1] == dir_q)) begin
                        state_d = ST_RAMP;
                    end else if (speed_d == '0) begin
                        state_d = ST_FLIP;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_FLIP: begin
                    // Speed is zero here, so this is the only safe place to reverse.
                    dir_d   = fv_s ? fd_s[FRAME_BITS-1] : tgt_q.dir;
                    state_d = ST_RAMP;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
`ifdef SPIN_WDOG_EN
            if (fv_s) begin
                wdog_d = 32'd0;
            end else if (wdog_q == WDOG_LAST) begin
                wdog_d      = 32'd0;
                tgt_d.speed = '0;
                state_d     = ST_RAMP;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
`endif
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Controller registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            speed_q  <= '0;
            dir_q    <= 1'b0;
            pwm_en_q <= 1'b0;
            busy_q   <= 1'b0;
            div_q    <= '0;
            tgt_q    <= '0;
`ifdef SPIN_WDOG_EN
            wdog_q   <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            dir_q    <= dir_d;
            pwm_en_q <= pwm_en_d;
            busy_q   <= busy_d;
            div_q    <= div_d;
            tgt_q    <= tgt_d;
`ifdef SPIN_WDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    assign speed  = speed_q;
    assign dir    = dir_q;
    assign pwm_en = pwm_en_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_spin_ramp_ctrl.sv
// Testbench for spin_ramp_ctrl (RAMP_DIV=4, WDOG_CYCLES=64); honours SPIN_WDOG_EN.
module tb_spin_ramp_ctrl;

    localparam int RDIV = 4;
    localparam int WDOG = 64;
    localparam int M_IDLE = 0, M_RAMP = 1, M_STOP = 2, M_FLIP = 3;

    logic       clk = 1'b0;
    logic       rst, en, f_en, freq;
    logic [3:0] speed;
    logic       dir, pwm_en, busy;

    spin_ramp_ctrl #(.RAMP_DIV(RDIV), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .en(en), .f_en(f_en), .freq(freq),
        .speed(speed), .dir(dir), .pwm_en(pwm_en), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: plain integers and a bit queue.
    int m_speed, m_dir, m_pwm, m_mode, m_phase, m_pend, m_pend_val;
    int m_prev_fen, m_tdir, m_tspd, m_wd;
    bit m_bits[$];
    logic prev_dut_dir;

    typedef struct packed {
        logic [4:0] frame;
        logic [3:0] spd;
        logic       dr;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic fe, input logic fq);
        int fv_l, fd_l, ndir, nspd, tick_l, edge_l, v;
        if (r) begin
            m_speed = 0; m_dir = 0; m_pwm = 0; m_mode = M_IDLE; m_phase = 0;
            m_pend = 0; m_pend_val = 0; m_prev_fen = 0; m_tdir = 0; m_tspd = 0; m_wd = 0;
            m_bits.delete();
            return;
        end
        edge_l = (fe && (m_prev_fen == 0)) ? 1 : 0;
        m_prev_fen = fe;
        m_pwm = (e && (m_speed != 0)) ? 1 : 0;
        if (!e) return;
        tick_l  = (m_phase == RDIV - 1) ? 1 : 0;
        m_phase = (m_phase + 1) % RDIV;
        fv_l = m_pend; fd_l = m_pend_val; m_pend = 0;
        if (edge_l != 0) begin
            m_bits.push_back(fq);
            if (m_bits.size() == 5) begin
                v = 0;
                for (int i = 0; i < 5; i++) v = v * 2 + int'(m_bits[i]);
                m_pend_val = v; m_pend = 1;
                m_bits.delete();
            end
        end
        ndir = fd_l / 16; nspd = fd_l % 16;
        case (m_mode)
            M_IDLE: if (fv_l != 0) m_mode = (ndir == m_dir) ? M_RAMP : ((m_speed != 0) ? M_STOP : M_FLIP);
            M_RAMP: begin
                if (tick_l != 0) begin
                    if (m_speed < m_tspd) m_speed++;
                    else if (m_speed > m_tspd) m_speed--;
                end
                if ((fv_l != 0) && (ndir != m_dir)) m_mode = M_STOP;
                else if ((fv_l == 0) && (m_speed == m_tspd)) m_mode = M_IDLE;
            end
            M_STOP: begin
                if ((tick_l != 0) && (m_speed > 0)) m_speed--;
                if ((fv_l != 0) && (ndir == m_dir)) m_mode = M_RAMP;
                else if (m_speed == 0) m_mode = M_FLIP;
            end
            default: begin
                m_dir  = (fv_l != 0) ? ndir : m_tdir;
                m_mode = M_RAMP;
            end
        endcase
        if (fv_l != 0) begin m_tdir = ndir; m_tspd = nspd; end
`ifdef SPIN_WDOG_EN
        if (fv_l != 0) m_wd = 0;
        else if (m_wd == WDOG - 1) begin m_wd = 0; m_tspd = 0; m_mode = M_RAMP; end
        else m_wd++;
`endif
    endtask

    // One clock: model consumes the pre-edge inputs, then outputs are compared.
    task automatic step();
        logic r, e, fe, fq;
        r = rst; e = en; fe = f_en; fq = freq;
        @(posedge clk);
        model_step(r, e, fe, fq);
        #1;
        chk("speed", speed, m_speed);
        chk("dir", dir, m_dir);
        chk("pwm_en", pwm_en, m_pwm);
        chk("busy", busy, (m_mode != M_IDLE) ? 1 : 0);
        if (dir !== prev_dut_dir) chk("dir_change_at_speed0", speed, 0);
        prev_dut_dir = dir;
    endtask

    task automatic send_bits(input logic [4:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            freq = v[4 - i]; f_en = 1'b1; step();
            f_en = 1'b0; step();
        end
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((busy !== 1'b0) && (k < bound)) begin step(); k++; end
        chk("settle_timeout", busy, 0);
    endtask

    initial begin
        int s;
        tbl[0] = '{frame: 5'b01010, spd: 4'd10, dr: 1'b0};
        tbl[1] = '{frame: 5'b10011, spd: 4'd3,  dr: 1'b1};
        tbl[2] = '{frame: 5'b11111, spd: 4'd15, dr: 1'b1};
        tbl[3] = '{frame: 5'b00000, spd: 4'd0,  dr: 1'b0};
        tbl[4] = '{frame: 5'b00101, spd: 4'd5,  dr: 1'b0};

        prev_dut_dir = 1'b0;
        rst = 1'b1; en = 1'b1; f_en = 1'b0; freq = 1'b0;
        @(posedge clk); model_step(1'b1, 1'b1, 1'b0, 1'b0); #1;
        prev_dut_dir = dir;
        step();
        chk("rst_speed", speed, 0); chk("rst_dir", dir, 0);
        chk("rst_pwm", pwm_en, 0);  chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Table of frames, each checked once the ramp settles.
        for (int t = 0; t < 5; t++) begin
            send_bits(tbl[t].frame, 5);
            wait_idle(200);
            chk("tbl_speed", speed, tbl[t].spd);
            chk("tbl_dir", dir, tbl[t].dr);
            step();
            chk("tbl_pwm", pwm_en, (tbl[t].spd != 4'd0) ? 1 : 0);
        end

        // Frame lands on a tick: old target 8 still steps 4 -> 5, then down to 2.
        send_bits(5'b00000, 5); wait_idle(200);
        send_bits(5'b01000, 5);
        send_bits(5'b00010, 4);
        s = 0;
        while (!((m_speed == 4) && (m_phase == RDIV - 2)) && (s < 100)) begin step(); s++; end
        chk("align_timeout", (s < 100) ? 1 : 0, 1);
        freq = 1'b0; f_en = 1'b1; step();
        f_en = 1'b0; step();
        chk("coincide_speed", speed, 5);
        wait_idle(200);
        chk("coincide_final", speed, 2);

        // Reset mid-ramp with a partial frame pending.
        send_bits(5'b01100, 5);
        s = 0;
        while ((speed !== 4'd5) && (s < 100)) begin step(); s++; end
        send_bits(5'b11111, 3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_speed", speed, 0); chk("rst_mid_dir", dir, 0);
        chk("rst_mid_pwm", pwm_en, 0);  chk("rst_mid_busy", busy, 0);
        send_bits(5'b00011, 5); wait_idle(200);
        chk("post_rst_speed", speed, 3);

        // Enable low for 20 cycles during a ramp, with f_en pulses.
        send_bits(5'b01010, 5); step(); step();
        s = int'(speed);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            f_en = (i % 2 == 0) ? 1'b1 : 1'b0; freq = 1'($urandom_range(0, 1));
            step();
            chk("freeze_speed", speed, s);
        end
        en = 1'b1; f_en = 1'b0;
        wait_idle(200);
        chk("resume_speed", speed, 10);

        // Frame timeout behaviour.
        send_bits(5'b00110, 5); wait_idle(200);
        chk("wd_start", speed, 6);
        for (int i = 0; i < 100; i++) step();
`ifdef SPIN_WDOG_EN
        chk("wd_speed", speed, 0); chk("wd_pwm", pwm_en, 0);
`else
        chk("wd_speed", speed, 6); chk("wd_pwm", pwm_en, 1);
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0;
            en   = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
            f_en = ($urandom_range(0, (i < 1500) ? 2 : 7) == 0) ? 1'b1 : 1'b0;
            freq = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; en = 1'b1; f_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
